// File: rtl/wr_req_xbar_rr.sv
// N-to-M write-request crossbar: per-bank round-robin arbitration joined
// with DB entry allocation, feeding a small per-bank output FIFO.
module wr_req_xbar_rr #(
    parameter  int IN_NUM    = 8,
    parameter  int OUT_NUM   = 4,
    parameter  int ADDR_W    = 64,
    parameter  int DATA_W    = 1024,
    parameter  int STRB_W    = DATA_W / 8,
    parameter  int TXNID_W   = 8,
    parameter  int SB_W      = 4,
    parameter  int DB_IDX_W  = 6,
    parameter  int OUT_DEPTH = 2,
    localparam int SRC_W     = (IN_NUM > 1) ? $clog2(IN_NUM) : 1,
    localparam int LVL_W     = $clog2(OUT_DEPTH) + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [IN_NUM-1:0]                  wr_cmd_vld,
    output logic [IN_NUM-1:0]                  wr_cmd_rdy,
    input  logic [IN_NUM-1:0][ADDR_W-1:0]      wr_addr,
    input  logic [IN_NUM-1:0][DATA_W-1:0]      wr_data,
    input  logic [IN_NUM-1:0][STRB_W-1:0]      wr_strb,
    input  logic [IN_NUM-1:0][TXNID_W-1:0]     wr_cmd_txnid,
    input  logic [IN_NUM-1:0][SB_W-1:0]        wr_sideband,
    input  logic [OUT_NUM-1:0]                 alloc_vld,
    input  logic [OUT_NUM-1:0][DB_IDX_W-1:0]   alloc_idx,
    output logic [OUT_NUM-1:0]                 alloc_rdy,
    output logic [OUT_NUM-1:0]                 out_vld,
    output logic [OUT_NUM-1:0][ADDR_W-1:0]     out_addr,
    output logic [OUT_NUM-1:0][DATA_W-1:0]     out_data,
    output logic [OUT_NUM-1:0][STRB_W-1:0]     out_strb,
    output logic [OUT_NUM-1:0][TXNID_W-1:0]    out_txnid,
    output logic [OUT_NUM-1:0][SB_W-1:0]       out_sideband,
    output logic [OUT_NUM-1:0][DB_IDX_W-1:0]   out_db_entry_id,
    output logic [OUT_NUM-1:0][SRC_W-1:0]      out_src_id,
    input  logic [OUT_NUM-1:0]                 out_rdy,
    output logic [OUT_NUM-1:0][LVL_W-1:0]      out_level
);

    localparam int SEL_W = $clog2(OUT_NUM);
    localparam int PTR_W = $clog2(OUT_DEPTH);

    logic [OUT_NUM-1:0][SRC_W-1:0] rr_ptr;
    logic [OUT_NUM-1:0][SRC_W-1:0] win;
    logic [OUT_NUM-1:0][PTR_W-1:0] wr_ptr;
    logic [OUT_NUM-1:0][PTR_W-1:0] rd_ptr;
    logic [OUT_NUM-1:0][LVL_W-1:0] level;
    logic [OUT_NUM-1:0][IN_NUM-1:0] req;
    logic [OUT_NUM-1:0] any_req;
    logic [OUT_NUM-1:0] push;
    logic [OUT_NUM-1:0] pop;
    logic [OUT_NUM-1:0] can_push;

    logic [ADDR_W-1:0]   q_addr [OUT_NUM][OUT_DEPTH];
    logic [DATA_W-1:0]   q_data [OUT_NUM][OUT_DEPTH];
    logic [STRB_W-1:0]   q_strb [OUT_NUM][OUT_DEPTH];
    logic [TXNID_W-1:0]  q_txnid [OUT_NUM][OUT_DEPTH];
    logic [SB_W-1:0]     q_sb [OUT_NUM][OUT_DEPTH];
    logic [DB_IDX_W-1:0] q_db [OUT_NUM][OUT_DEPTH];
    logic [SRC_W-1:0]    q_src [OUT_NUM][OUT_DEPTH];

    always_comb begin
        int idx;
        idx     = 0;
        req     = '0;
        win     = '0;
        any_req = '0;
        for (int b = 0; b < OUT_NUM; b++) begin
            for (int i = 0; i < IN_NUM; i++) begin
                req[b][i] = wr_cmd_vld[i] &&
                    (wr_addr[i][ADDR_W-1 -: SEL_W] == SEL_W'(b));
            end
            // Scan from the far end so the hit nearest rr_ptr wins last.
            for (int k = IN_NUM - 1; k >= 0; k--) begin
                idx = (int'(rr_ptr[b]) + k) % IN_NUM;
                if (req[b][idx]) begin
                    any_req[b] = 1'b1;
                    win[b]     = SRC_W'(idx);
                end
            end
        end
    end

    always_comb begin
        wr_cmd_rdy = '0;
        alloc_rdy  = '0;
        pop        = '0;
        can_push   = '0;
        push       = '0;
        for (int b = 0; b < OUT_NUM; b++) begin
            pop[b]      = (level[b] != '0) && out_rdy[b];
            can_push[b] = (level[b] < LVL_W'(OUT_DEPTH)) || pop[b];
            push[b]     = !rst && any_req[b] && alloc_vld[b] && can_push[b];
            alloc_rdy[b] = push[b];
            if (push[b]) begin
                wr_cmd_rdy[win[b]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            for (int b = 0; b < OUT_NUM; b++) begin
                if (push[b]) begin
                    rr_ptr[b] <= (win[b] == SRC_W'(IN_NUM - 1)) ?
                                 '0 : win[b] + 1'b1;
                    wr_ptr[b] <= wr_ptr[b] + 1'b1;
                end
                if (pop[b]) begin
                    rd_ptr[b] <= rd_ptr[b] + 1'b1;
                end
                if (push[b] && !pop[b]) begin
                    level[b] <= level[b] + 1'b1;
                end else if (pop[b] && !push[b]) begin
                    level[b] <= level[b] - 1'b1;
                end
            end
        end
    end

    // Payload storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < OUT_NUM; b++) begin
            if (push[b]) begin
                q_addr[b][wr_ptr[b]]  <= wr_addr[win[b]];
                q_data[b][wr_ptr[b]]  <= wr_data[win[b]];
                q_strb[b][wr_ptr[b]]  <= wr_strb[win[b]];
                q_txnid[b][wr_ptr[b]] <= wr_cmd_txnid[win[b]];
                q_sb[b][wr_ptr[b]]    <= wr_sideband[win[b]];
                q_db[b][wr_ptr[b]]    <= alloc_idx[b];
                q_src[b][wr_ptr[b]]   <= win[b];
            end
        end
    end

    always_comb begin
        out_vld         = '0;
        out_addr        = '0;
        out_data        = '0;
        out_strb        = '0;
        out_txnid       = '0;
        out_sideband    = '0;
        out_db_entry_id = '0;
        out_src_id      = '0;
        for (int b = 0; b < OUT_NUM; b++) begin
            out_vld[b]         = level[b] != '0;
            out_addr[b]        = q_addr[b][rd_ptr[b]];
            out_data[b]        = q_data[b][rd_ptr[b]];
            out_strb[b]        = q_strb[b][rd_ptr[b]];
            out_txnid[b]       = q_txnid[b][rd_ptr[b]];
            out_sideband[b]    = q_sb[b][rd_ptr[b]];
            out_db_entry_id[b] = q_db[b][rd_ptr[b]];
            out_src_id[b]      = q_src[b][rd_ptr[b]];
        end
    end

    assign out_level = level;

endmodule

// File: tb/tb_wr_req_xbar_rr.sv
// Bench for wr_req_xbar_rr: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_wr_req_xbar_rr;

    localparam int IN_NUM    = 8;
    localparam int OUT_NUM   = 4;
    localparam int ADDR_W    = 64;
    localparam int DATA_W    = 64;
    localparam int STRB_W    = 8;
    localparam int TXNID_W   = 8;
    localparam int SB_W      = 4;
    localparam int DB_IDX_W  = 6;
    localparam int OUT_DEPTH = 2;
    localparam int SRC_W     = 3;
    localparam int LVL_W     = 2;

    logic clk;
    logic rst;
    logic [IN_NUM-1:0]                wr_cmd_vld;
    logic [IN_NUM-1:0]                wr_cmd_rdy;
    logic [IN_NUM-1:0][ADDR_W-1:0]    wr_addr;
    logic [IN_NUM-1:0][DATA_W-1:0]    wr_data;
    logic [IN_NUM-1:0][STRB_W-1:0]    wr_strb;
    logic [IN_NUM-1:0][TXNID_W-1:0]   wr_cmd_txnid;
    logic [IN_NUM-1:0][SB_W-1:0]      wr_sideband;
    logic [OUT_NUM-1:0]               alloc_vld;
    logic [OUT_NUM-1:0][DB_IDX_W-1:0] alloc_idx;
    logic [OUT_NUM-1:0]               alloc_rdy;
    logic [OUT_NUM-1:0]               out_vld;
    logic [OUT_NUM-1:0][ADDR_W-1:0]   out_addr;
    logic [OUT_NUM-1:0][DATA_W-1:0]   out_data;
    logic [OUT_NUM-1:0][STRB_W-1:0]   out_strb;
    logic [OUT_NUM-1:0][TXNID_W-1:0]  out_txnid;
    logic [OUT_NUM-1:0][SB_W-1:0]     out_sideband;
    logic [OUT_NUM-1:0][DB_IDX_W-1:0] out_db_entry_id;
    logic [OUT_NUM-1:0][SRC_W-1:0]    out_src_id;
    logic [OUT_NUM-1:0]               out_rdy;
    logic [OUT_NUM-1:0][LVL_W-1:0]    out_level;

    wr_req_xbar_rr #(
        .IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .STRB_W(STRB_W), .TXNID_W(TXNID_W),
        .SB_W(SB_W), .DB_IDX_W(DB_IDX_W), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_cmd_vld(wr_cmd_vld), .wr_cmd_rdy(wr_cmd_rdy),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_cmd_txnid(wr_cmd_txnid), .wr_sideband(wr_sideband),
        .alloc_vld(alloc_vld), .alloc_idx(alloc_idx),
        .alloc_rdy(alloc_rdy), .out_vld(out_vld), .out_addr(out_addr),
        .out_data(out_data), .out_strb(out_strb), .out_txnid(out_txnid),
        .out_sideband(out_sideband), .out_db_entry_id(out_db_entry_id),
        .out_src_id(out_src_id), .out_rdy(out_rdy), .out_level(out_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit auto_drop = 1'b1;

    typedef struct {
        logic [IN_NUM-1:0]       vld;
        logic [IN_NUM-1:0][1:0]  sel;
        logic [OUT_NUM-1:0]      alloc;
        logic [IN_NUM-1:0]       exp_rdy;
        logic [OUT_NUM-1:0]      exp_arr;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [STRB_W-1:0]   strb;
        logic [TXNID_W-1:0]  txn;
        logic [SB_W-1:0]     sb;
        logic [DB_IDX_W-1:0] db;
        int                  src;
    } ent_t;

    vec_t vecs[6];
    ent_t mq[OUT_NUM][$];
    ent_t pend[OUT_NUM];
    int   mrr[OUT_NUM];
    int   mwin[OUT_NUM];
    bit   macc[OUT_NUM];
    bit   mpop[OUT_NUM];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_fields(input int i, input int bank);
        wr_addr[i]      = {2'(bank), 30'($urandom), 32'($urandom)};
        wr_data[i]      = {$urandom, $urandom};
        wr_strb[i]      = 8'($urandom);
        wr_cmd_txnid[i] = 8'($urandom);
        wr_sideband[i]  = 4'($urandom);
    endtask

    task automatic tick();
        logic [IN_NUM-1:0] g;
        g = wr_cmd_rdy;
        @(posedge clk);
        #1;
        if (auto_drop) wr_cmd_vld = wr_cmd_vld & ~g;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_cmd_vld = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [IN_NUM-1:0] e;
        int ord[6];
        ent_t s;

        rst = 1'b1;
        wr_cmd_vld = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        wr_cmd_txnid = '0; wr_sideband = '0;
        alloc_vld = '0; alloc_idx = '0; out_rdy = '0;
        @(posedge clk);
        #1;
        chk("rst_out_vld", out_vld, 4'h0);
        chk("rst_level", out_level, 8'h00);
        rst = 1'b0;

        vecs[0] = '{8'h08, {2'd0,2'd0,2'd0,2'd0,2'd2,2'd0,2'd0,2'd0},
                    4'b0100, 8'h08, 4'b0100};
        vecs[1] = '{8'h23, {2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0},
                    4'b1111, 8'h01, 4'b0001};
        vecs[2] = '{8'h06, {2'd0,2'd0,2'd0,2'd0,2'd0,2'd1,2'd1,2'd0},
                    4'b1101, 8'h00, 4'b0000};
        vecs[3] = '{8'h0F, {2'd0,2'd0,2'd0,2'd0,2'd3,2'd2,2'd1,2'd0},
                    4'b1111, 8'h0F, 4'b1111};
        vecs[4] = '{8'hF0, {2'd3,2'd3,2'd2,2'd2,2'd0,2'd0,2'd0,2'd0},
                    4'b1000, 8'h40, 4'b1000};
        vecs[5] = '{8'h00, {2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0},
                    4'b1111, 8'h00, 4'b0000};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            out_rdy = '1;
            alloc_vld = vecs[v].alloc;
            for (int i = 0; i < IN_NUM; i++) drive_fields(i, vecs[v].sel[i]);
            wr_cmd_vld = vecs[v].vld;
            #1;
            chk("tbl_rdy", wr_cmd_rdy, vecs[v].exp_rdy);
            chk("tbl_alloc_rdy", alloc_rdy, vecs[v].exp_arr);
            tick();
            chk("tbl_out_vld", out_vld, vecs[v].exp_arr);
            wr_cmd_vld = '0;
        end

        // single request with payload check
        do_reset();
        out_rdy = '0;
        alloc_vld = 4'b0100;
        alloc_idx[2] = 6'd5;
        drive_fields(3, 2);
        wr_cmd_vld = 8'h08;
        s = '{wr_addr[3], wr_data[3], wr_strb[3], wr_cmd_txnid[3],
              wr_sideband[3], 6'd5, 3};
        #1;
        chk("single_rdy", wr_cmd_rdy, 8'h08);
        chk("single_alloc_rdy", alloc_rdy, 4'b0100);
        tick();
        chk("single_out_vld", out_vld, 4'b0100);
        chk("single_db", out_db_entry_id[2], 6'd5);
        chk("single_src", out_src_id[2], 3'd3);
        chk("single_addr", out_addr[2], s.addr);
        chk("single_data", out_data[2], s.data);
        chk("single_strb", out_strb[2], s.strb);
        chk("single_txnid", out_txnid[2], s.txn);
        chk("single_sb", out_sideband[2], s.sb);
        chk("single_level", out_level[2], 2'd1);

        // round robin over held requests 0,1,5
        do_reset();
        auto_drop = 1'b0;
        out_rdy = '1;
        alloc_vld = '1;
        drive_fields(0, 0); drive_fields(1, 0); drive_fields(5, 0);
        wr_cmd_vld = 8'h23;
        ord = '{0, 1, 5, 0, 1, 5};
        for (int k = 0; k < 6; k++) begin
            #1;
            e = 8'd1 << ord[k];
            chk("rr_grant", wr_cmd_rdy, e);
            tick();
        end
        auto_drop = 1'b1;
        wr_cmd_vld = '0;

        // alloc stall holds the pointer
        do_reset();
        alloc_vld = 4'b0010;
        drive_fields(2, 1); drive_fields(4, 1);
        wr_cmd_vld = 8'h14;
        #1;
        chk("stall_first", wr_cmd_rdy, 8'h04);
        tick();
        wr_cmd_vld = 8'h14;
        alloc_vld = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("stall_rdy", wr_cmd_rdy, 8'h00);
            chk("stall_alloc_rdy", alloc_rdy, 4'b0000);
            tick();
        end
        alloc_vld = 4'b0010;
        #1;
        chk("stall_resume", wr_cmd_rdy, 8'h10);
        chk("stall_resume_alloc", alloc_rdy, 4'b0010);
        tick();
        wr_cmd_vld = '0;

        // full FIFO, then pop+push in one cycle
        do_reset();
        out_rdy = 4'b0111;
        alloc_vld = '1;
        drive_fields(0, 3); drive_fields(1, 3); drive_fields(2, 3);
        wr_cmd_vld = 8'h07;
        #1;
        chk("full_g0", wr_cmd_rdy, 8'h01);
        tick();
        #1;
        chk("full_g1", wr_cmd_rdy, 8'h02);
        tick();
        #1;
        chk("full_stall", wr_cmd_rdy, 8'h00);
        chk("full_alloc_rdy", alloc_rdy, 4'b0000);
        chk("full_level", out_level[3], 2'd2);
        tick();
        out_rdy = 4'b1111;
        #1;
        chk("full_pushpop", wr_cmd_rdy, 8'h04);
        tick();
        out_rdy = 4'b0111;
        chk("full_level_hold", out_level[3], 2'd2);
        chk("full_head_src", out_src_id[3], 3'd1);
        wr_cmd_vld = '0;

        // parallel banks, bank 0 stalled
        do_reset();
        auto_drop = 1'b0;
        out_rdy = 4'b1110;
        alloc_vld = '1;
        for (int i = 0; i < 4; i++) drive_fields(i, i);
        wr_cmd_vld = 8'h0F;
        #1;
        chk("par_rdy0", wr_cmd_rdy, 8'h0F);
        tick();
        chk("par_out_vld", out_vld, 4'hF);
        #1;
        chk("par_rdy1", wr_cmd_rdy, 8'h0F);
        tick();
        #1;
        chk("par_rdy2", wr_cmd_rdy, 8'h0E);
        tick();
        chk("par_level0", out_level[0], 2'd2);

        // asynchronous reset mid-stream
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_vld", out_vld, 4'h0);
        chk("arst_level", out_level, 8'h00);
        chk("arst_rdy", wr_cmd_rdy, 8'h00);
        chk("arst_alloc_rdy", alloc_rdy, 4'h0);
        #2;
        rst = 1'b0;
        auto_drop = 1'b1;
        out_rdy = '1;
        drive_fields(1, 1); drive_fields(3, 1);
        wr_cmd_vld = 8'h0A;
        #1;
        chk("arst_first_grant", wr_cmd_rdy, 8'h02);
        tick();
        wr_cmd_vld = '0;

        // randomized run against the reference model
        do_reset();
        auto_drop = 1'b0;
        for (int b = 0; b < OUT_NUM; b++) begin
            mq[b].delete();
            mrr[b] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < IN_NUM; i++) begin
                drive_fields(i, $urandom_range(0, 3));
                wr_cmd_vld[i] = ($urandom_range(0, 2) != 0);
            end
            for (int b = 0; b < OUT_NUM; b++) begin
                alloc_vld[b] = ($urandom_range(0, 3) != 0);
                alloc_idx[b] = 6'($urandom);
                out_rdy[b]   = ($urandom_range(0, 3) != 0);
            end
            #1;
            e = '0;
            for (int b = 0; b < OUT_NUM; b++) begin
                int sz;
                sz = mq[b].size();
                chk("rnd_out_vld", out_vld[b], sz > 0);
                chk("rnd_level", out_level[b], sz);
                if (sz > 0) begin
                    chk("rnd_addr", out_addr[b], mq[b][0].addr);
                    chk("rnd_data", out_data[b], mq[b][0].data);
                    chk("rnd_db", out_db_entry_id[b], mq[b][0].db);
                    chk("rnd_src", out_src_id[b], mq[b][0].src);
                    chk("rnd_txn", out_txnid[b], mq[b][0].txn);
                end
                mpop[b] = (sz > 0) && out_rdy[b];
                mwin[b] = -1;
                for (int k = 0; k < IN_NUM; k++) begin
                    int i;
                    i = (mrr[b] + k) % IN_NUM;
                    if (mwin[b] < 0 && wr_cmd_vld[i] &&
                        wr_addr[i][ADDR_W-1 -: 2] == 2'(b))
                        mwin[b] = i;
                end
                macc[b] = (mwin[b] >= 0) && alloc_vld[b] &&
                          (sz < OUT_DEPTH || mpop[b]);
                if (macc[b]) begin
                    e[mwin[b]] = 1'b1;
                    pend[b] = '{wr_addr[mwin[b]], wr_data[mwin[b]],
                                wr_strb[mwin[b]], wr_cmd_txnid[mwin[b]],
                                wr_sideband[mwin[b]], alloc_idx[b], mwin[b]};
                end
                chk("rnd_alloc_rdy", alloc_rdy[b], macc[b]);
            end
            chk("rnd_rdy", wr_cmd_rdy, e);
            tick();
            for (int b = 0; b < OUT_NUM; b++) begin
                if (mpop[b]) void'(mq[b].pop_front());
                if (macc[b]) begin
                    mq[b].push_back(pend[b]);
                    mrr[b] = (mwin[b] + 1) % IN_NUM;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wr_req_xbar_rr.md
Name: wr_req_xbar_rr

Overview:
- Parametrised N-to-M write-request crossbar for the vector cache front end.
- Each input write command (addr/data/strb/txnid/sideband) is routed to a bank selected by the top address bits.
- Each bank runs its own round-robin arbiter. A grant is joined atomically with a data-buffer entry allocation.
- The request and its db_entry_id are registered into a per-bank output FIFO that drives the bank pipeline.

Parameters:
- IN_NUM, 8: number of write request ports (>=1)
- OUT_NUM, 4: number of banks/outputs (power of 2, >=2)
- ADDR_W, 64: request address width
- DATA_W, 1024: write data width
- STRB_W, DATA_W/8: byte strobe width
- TXNID_W, TXNID_WIDTH: transaction id width
- SB_W, SIDEBAND_WIDTH: sideband width
- DB_IDX_W, DB_ENTRY_IDX_WIDTH: data-buffer entry index width
- OUT_DEPTH, 2: per-bank output FIFO depth (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wr_cmd_vld  in  IN_NUM  per-input request valid
- wr_cmd_rdy  out  IN_NUM  per-input accept
- wr_addr  in  ADDR_W x IN_NUM  request address
- wr_data  in  DATA_W x IN_NUM  write data
- wr_strb  in  STRB_W x IN_NUM  byte strobes
- wr_cmd_txnid  in  TXNID_W x IN_NUM  transaction id
- wr_sideband  in  SB_W x IN_NUM  sideband
- alloc_vld  in  OUT_NUM  per-bank free DB entry available
- alloc_idx  in  DB_IDX_W x OUT_NUM  offered DB entry index
- alloc_rdy  out  OUT_NUM  DB entry consumed this cycle
- out_vld  out  OUT_NUM  bank FIFO head valid
- out_addr, out_data, out_strb, out_txnid, out_sideband  out  per field x OUT_NUM  head payload
- out_db_entry_id  out  DB_IDX_W x OUT_NUM  allocated DB entry of head
- out_src_id  out  clog2(IN_NUM) x OUT_NUM  originating input port (min width 1)
- out_rdy  in  OUT_NUM  bank accepts head
- out_level  out  clog2(OUT_DEPTH)+1 x OUT_NUM  FIFO occupancy

Behaviour:
- Bank select: sel[i] = wr_addr[i][ADDR_W-1 -: clog2(OUT_NUM)]. Input i requests bank b when wr_cmd_vld[i] && sel[i]==b.
- Per bank b, arbitration is combinational. Winner = first requesting input at or after rr_ptr[b], with circular search over IN_NUM.
- accept[b] = any_req[b] && alloc_vld[b] && can_push[b].
- can_push[b] = (level[b] < OUT_DEPTH) || (out_vld[b] && out_rdy[b]). A push is allowed into a full FIFO when a pop happens in the same cycle.
- When accept[b] is high:
  - wr_cmd_rdy[winner] = 1 and alloc_rdy[b] = 1 in the same cycle.
  - Payload, alloc_idx[b] and winner index are written at the FIFO tail.
  - rr_ptr[b] <= (winner+1) mod IN_NUM.
- Otherwise wr_cmd_rdy and alloc_rdy are 0 for that bank, and rr_ptr is held.
- wr_cmd_rdy[i] is never asserted without wr_cmd_vld[i]. alloc_rdy[b] is never asserted without alloc_vld[b].
- Each input targets exactly one bank, so at most one rdy per input per cycle.
- Inputs must hold vld and payload stable until rdy. The block does not depend on this for correctness: arbitration is re-evaluated every cycle.
- Latency: an accepted request is visible at out_vld the next cycle (1 cycle). There is no bypass.
- FIFO:
  - out_vld[b] = level[b] != 0, with the head driven from registers.
  - Pop on out_vld && out_rdy.
  - Pointers wrap mod OUT_DEPTH.
  - Level increments on push-only, decrements on pop-only, holds on push+pop.
- Full throughput: one request per bank per cycle when out_rdy is held high and alloc_vld is held high.
- Banks are fully independent: a stall on one bank never blocks inputs targeting other banks.
- Reset (asynchronous):
  - Clears all rr_ptr to 0, FIFO pointers and levels to 0.
  - out_vld=0, out_level=0. wr_cmd_rdy=0 and alloc_rdy=0 while rst is high.
  - Payload registers are not reset.
  - Reset mid-operation discards FIFO contents. Allocated DB entries are not returned; that is the allocator's responsibility on reset.
- Opcode is not carried: all traffic is write.

Test Plan:
- Single request: input 3, addr[63:62]=2'b10, alloc_vld[2]=1, alloc_idx[2]=5 → wr_cmd_rdy[3] and alloc_rdy[2] in cycle 0; cycle 1: out_vld[2]=1, out_db_entry_id[2]=5, out_src_id[2]=3, data/strb/txnid match.
- Round-robin: inputs 0, 1, 5 hold requests to bank 0, with out_rdy and alloc_vld high → grant order 0, 1, 5, 0, 1, 5. Each wins exactly once per 3 cycles.
- Alloc stall: requests to bank 1 with alloc_vld[1]=0 → wr_cmd_rdy=0, alloc_rdy[1]=0, rr_ptr unchanged. Raising alloc_vld resumes with the same winner.
- FIFO full with OUT_DEPTH=2: out_rdy[3]=0, 3 requests → 2 accepted, out_level[3]=2, third stalls. Pulse out_rdy for 1 cycle → pop and push in the same cycle, level stays 2.
- Parallel banks: 4 inputs targeting 4 distinct banks in one cycle → all 4 rdy together, 4 out_vld next cycle. Stalling bank 0 does not affect the other 3.
- Reset mid-stream: assert rst asynchronously with out_level=2 → out_vld drops immediately, level=0, rr_ptr=0. After release, the first grant goes to the lowest requesting index.
